ntt_bfu_addsub: RTL and testbench
=================================

# ntt_bfu_addsub

Butterfly add/subtract back-end for the q = 12289 NTT datapath. It sits directly downstream of the pipelined modular multiplier: `in_valid`, `in_inv` and `u_in` are issued in the same cycle the multiplier receives its operands, and `prod_in` is the multiplier's reduced product, `MUL_LAT` cycles later. The block delays the upper operand to meet the product, then produces the Cooley-Tukey pair x = u + v mod q and y = u − v mod q. It also counts completed butterflies per NTT stage.

## Interface
- `DATA_W`, 14, coefficient width
- `Q`, 12289, modulus
- `MUL_LAT`, 5, cycles from issue until `prod_in` carries that issue's product (range 1..8)
- `BF_PER_STAGE`, 256, butterflies per stage (power of two)
- `clk`  input  1  clock; all state updates on rising edge
- `rst`  input  1  synchronous active-low reset
- `in_valid`  input  1  issue strobe for one butterfly
- `in_inv`  input  1  inverse-NTT flag, sampled with `in_valid`
- `u_in`  input  DATA_W  upper operand, in [0, Q−1]
- `prod_in`  input  DATA_W  reduced product ω·b from the multiplier, in [0, Q−1]
- `out_valid`  output  1  x/y valid strobe
- `x_out`  output  DATA_W  (u + v) mod Q, optionally halved
- `y_out`  output  DATA_W  (u − v) mod Q, optionally halved
- `bf_cnt`  output  log2(BF_PER_STAGE)  completed butterflies in the current stage
- `stage_done`  output  1  one-cycle pulse on the last butterfly of a stage

## Operation
- Alignment pipeline:
  - `MUL_LAT`-deep shift register carries {valid, inv, u}; it advances every cycle and has no stall.
  - The tail entry meets `prod_in` in the cycle it is valid.
  - Bubbles (`in_valid` = 0) propagate unchanged.
- Sum: s = u + v, computed 15-bit; if s ≥ Q then s −= Q.
- Difference: d = u − v, computed 15-bit signed; if d < 0 then d += Q.
- Halving: see Configuration. With halving, inv = 1 maps s → s/2 mod Q and d → d/2 mod Q:
  - even value → value >> 1
  - odd value → (value + Q) >> 1, with a 15-bit add
- Output registers:
  - `x_out`/`y_out` load only when the tail entry is valid.
  - Otherwise they hold their last value.
- Counter:
  - `bf_cnt` increments by 1 with each `out_valid` and wraps from BF_PER_STAGE−1 to 0.
  - `stage_done` is high in the same cycle as the `out_valid` whose result wraps the count, i.e. the BF_PER_STAGE-th output.
- Out-of-range inputs (≥ Q): results are undefined and are not checked.

## Timing
- Latency is `MUL_LAT` + 1 cycles: `in_valid` sampled at edge k gives `out_valid` high during cycle k + `MUL_LAT` + 1, which is 6 with defaults.
- Full throughput: one butterfly per cycle. Back-to-back issue gives back-to-back `out_valid`, and gaps between issues are preserved.
- `prod_in` is sampled at the edge ending cycle k + `MUL_LAT`; the block registers it at no other time.
- Reset (`rst` = 0 at an edge), effective after that edge:
  - `out_valid`, `stage_done`, all pipeline valid bits → 0
  - `bf_cnt` → 0
  - `x_out`, `y_out` → 0
  - Items in flight are discarded and never emerge.
  - `in_valid` is ignored while `rst` = 0.
- Counter: `bf_cnt` is registered and shows the new count in the cycle after the corresponding `out_valid`. `stage_done` is registered alongside `out_valid`.

## Configuration
- `NTT_BFU_HALVE_EN` defined:
  - the halving stage is compiled in
  - inv = 1 outputs (s/2, d/2) mod Q; inv = 0 outputs (s, d)
  - latency is unchanged; halving is combinational before the output register
- `NTT_BFU_HALVE_EN` undefined:
  - no halving logic is built
  - `in_inv` is accepted but ignored, and the inv bit is not stored in the pipeline
  - outputs are always (s, d)

## Test plan
- Basic: u = 5, prod = 7, inv = 0, issued at cycle 0 → `out_valid` at cycle 6 with x = 12, y = 12287.
- Wrap: u = 12288, prod = 1 → x = 0, y = 12287. u = 0, prod = 0 → x = 0, y = 0.
- Halving (macro on), inv = 1:
  - u = 3, prod = 0 → x = 6146, y = 6146
  - u = 4, prod = 2 → x = 3, y = 1
  - Same stimulus with the macro off → x = 3, y = 3 and x = 6, y = 2.
- Stage count: 256 back-to-back issues →
  - `out_valid` high for 256 consecutive cycles
  - `stage_done` pulses only with the 256th output
  - `bf_cnt` returns to 0
- Bubbles: issue pattern 1,0,1,1,0,1 → the `out_valid` pattern is identical, shifted by 6 cycles, with correct pairing of each u to its product.
- Reset mid-stream: drive `rst` = 0 for one edge while 3 items are in flight → `out_valid` = 0 and `bf_cnt` = 0 next cycle. None of the 3 items appear afterwards, and a new issue after reset emerges 6 cycles later.

Source files
------------

// File: rtl/ntt_bfu_addsub.sv
// ntt_bfu_addsub
// Butterfly add/subtract back-end for the q = 12289 NTT datapath.
// The upper operand is issued alongside the multiplier operands and is
// delayed MUL_LAT cycles so it meets the reduced product. The block then
// registers the Cooley-Tukey pair x = (u + v) mod Q and y = (u - v) mod Q,
// and counts completed butterflies per NTT stage.
//
// Optional feature macro: NTT_BFU_HALVE_EN
//   defined   -> inverse butterflies (inv = 1) output (s/2, d/2) mod Q
//   undefined -> no halving logic, in_inv is ignored, outputs are (s, d)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   issue strobe, same cycle the multiplier receives operands
//   in_inv     inverse-NTT flag, sampled with in_valid
//   u_in       upper operand, [0, Q-1]
//   prod_in    reduced product from the multiplier, MUL_LAT cycles after issue
//   out_valid  x_out/y_out valid strobe (latency MUL_LAT + 1)
//   x_out      (u + v) mod Q, optionally halved
//   y_out      (u - v) mod Q, optionally halved
//   bf_cnt     completed butterflies in the current stage
//   stage_done one-cycle pulse with the last butterfly of a stage
module ntt_bfu_addsub #(
    parameter int DATA_W       = 14,
    parameter int Q            = 12289,
    parameter int MUL_LAT      = 5,
    parameter int BF_PER_STAGE = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            in_inv,
    input  logic [DATA_W-1:0]               u_in,
    input  logic [DATA_W-1:0]               prod_in,
    output logic                            out_valid,
    output logic [DATA_W-1:0]               x_out,
    output logic [DATA_W-1:0]               y_out,
    output logic [$clog2(BF_PER_STAGE)-1:0] bf_cnt,
    output logic                            stage_done
);

    // One extra bit holds the carry of the sum and the sign of the difference.
    localparam int                SUM_W    = DATA_W + 1;
    localparam int                CNT_W    = $clog2(BF_PER_STAGE);
    localparam logic [SUM_W-1:0]  Q_EXT    = SUM_W'(Q);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BF_PER_STAGE - 1);

    // Alignment pipeline: index 0 is loaded at issue, index MUL_LAT-1 is the
    // tail entry that meets prod_in.
    logic [MUL_LAT-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]  u_q [MUL_LAT];
    logic [DATA_W-1:0]  u_d [MUL_LAT];
`ifdef NTT_BFU_HALVE_EN
    logic [MUL_LAT-1:0] inv_q, inv_d;
`endif

    logic                out_valid_q, out_valid_d;
    logic                stage_done_q, stage_done_d;
    logic [DATA_W-1:0]   x_q, x_d;
    logic [DATA_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]    bf_cnt_q, bf_cnt_d;

    logic                tail_valid;
    logic [DATA_W-1:0]   u_tail;
    logic [SUM_W-1:0]    sum_raw, sum_mod;
    logic [SUM_W-1:0]    diff_raw, diff_mod;
    logic [DATA_W-1:0]   x_res, y_res;

`ifdef NTT_BFU_HALVE_EN
    // Division by two mod an odd Q: odd values are made even by adding Q.
    // val < Q, so val + Q < 2Q still fits in SUM_W bits.
    function automatic logic [DATA_W-1:0] halve_mod(input logic [SUM_W-1:0] val);
        logic [SUM_W-1:0] adj;
        adj = val[0] ? (val + Q_EXT) : val;
        return adj[SUM_W-1:1];
    endfunction
`else
    // The inv flag and the top bits of the reduced values carry no
    // information when halving is not built.
    logic unused_bits;
    assign unused_bits = ^{in_inv, sum_mod[SUM_W-1], diff_mod[SUM_W-1]};
`endif

    // Shift the issue information one stage per cycle; there is no stall.
    always_comb begin
        valid_d    = '0;
        valid_d[0] = in_valid;
        u_d[0]     = u_in;
        for (int i = 1; i < MUL_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            u_d[i]     = u_q[i-1];
        end
`ifdef NTT_BFU_HALVE_EN
        inv_d    = '0;
        inv_d[0] = in_inv;
        for (int i = 1; i < MUL_LAT; i++) begin
            inv_d[i] = inv_q[i-1];
        end
`endif
    end

    // Modular add/subtract on the tail entry and the current product.
    always_comb begin
        tail_valid = valid_q[MUL_LAT-1];
        u_tail     = u_q[MUL_LAT-1];
        sum_raw    = {1'b0, u_tail} + {1'b0, prod_in};
        sum_mod    = (sum_raw >= Q_EXT) ? (sum_raw - Q_EXT) : sum_raw;
        // Operands are below 2^DATA_W, so the MSB is a valid sign bit.
        diff_raw   = {1'b0, u_tail} - {1'b0, prod_in};
        diff_mod   = diff_raw[SUM_W-1] ? (diff_raw + Q_EXT) : diff_raw;
`ifdef NTT_BFU_HALVE_EN
        if (inv_q[MUL_LAT-1]) begin
            x_res = halve_mod(sum_mod);
            y_res = halve_mod(diff_mod);
        end else begin
            x_res = sum_mod[DATA_W-1:0];
            y_res = diff_mod[DATA_W-1:0];
        end
`else
        x_res = sum_mod[DATA_W-1:0];
        y_res = diff_mod[DATA_W-1:0];
`endif
    end

    // Output registers load only for a valid tail entry and hold otherwise.
    // bf_cnt_d folds in the output currently on out_valid, so comparing it
    // with the last index marks the result that will wrap the count.
    always_comb begin
        out_valid_d  = tail_valid;
        x_d          = tail_valid ? x_res : x_q;
        y_d          = tail_valid ? y_res : y_q;
        bf_cnt_d     = out_valid_q ? (bf_cnt_q + CNT_W'(1)) : bf_cnt_q;
        stage_done_d = tail_valid && (bf_cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                u_q[i] <= '0;
            end
`ifdef NTT_BFU_HALVE_EN
            inv_q        <= '0;
`endif
            out_valid_q  <= 1'b0;
            stage_done_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            bf_cnt_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            u_q          <= u_d;
`ifdef NTT_BFU_HALVE_EN
            inv_q        <= inv_d;
`endif
            out_valid_q  <= out_valid_d;
            stage_done_q <= stage_done_d;
            x_q          <= x_d;
            y_q          <= y_d;
            bf_cnt_q     <= bf_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign stage_done = stage_done_q;
    assign x_out      = x_q;
    assign y_out      = y_q;
    assign bf_cnt     = bf_cnt_q;

endmodule

// File: tb/tb_ntt_bfu_addsub.sv
// tb_ntt_bfu_addsub
// Directed bench for ntt_bfu_addsub with default parameters. A small delay
// line stands in for the upstream multiplier so that prod_in carries each
// issue's product MUL_LAT cycles after the issue. Inputs are driven and
// outputs sampled on the falling edge.
module tb_ntt_bfu_addsub;

    localparam int          MUL_LAT   = 5;
    localparam int          QV        = 12289;
    localparam logic [13:0] IDLE_PROD = 14'd9999;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_inv;
    logic [13:0] u_in;
    logic [13:0] prod_in;
    logic        out_valid;
    logic [13:0] x_out;
    logic [13:0] y_out;
    logic [7:0]  bf_cnt;
    logic        stage_done;

    logic [13:0] iss_prod;
    logic [13:0] mult_pipe [MUL_LAT];

    int errors = 0;
    int checks = 0;

    ntt_bfu_addsub dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_inv     (in_inv),
        .u_in       (u_in),
        .prod_in    (prod_in),
        .out_valid  (out_valid),
        .x_out      (x_out),
        .y_out      (y_out),
        .bf_cnt     (bf_cnt),
        .stage_done (stage_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream multiplier stand-in: the product given with an issue shows
    // up on prod_in MUL_LAT cycles later.
    always @(posedge clk) begin
        mult_pipe[0] <= iss_prod;
        for (int i = 1; i < MUL_LAT; i++) begin
            mult_pipe[i] <= mult_pipe[i-1];
        end
    end
    assign prod_in = mult_pipe[MUL_LAT-1];

    // Issue one butterfly and wait (bounded) for out_valid; lat counts
    // falling edges from the drive point, 20 means it never came.
    task automatic run_single(input logic [13:0] u, input logic [13:0] p, input logic inv,
                              output logic [13:0] xo, output logic [13:0] yo, output int lat);
        in_valid = 1'b1; u_in = u; iss_prod = p; in_inv = inv;
        @(negedge clk);
        lat = 1;
        in_valid = 1'b0; u_in = '0; iss_prod = IDLE_PROD; in_inv = 1'b0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        xo = x_out;
        yo = y_out;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int stray;
        rst = 1'b0;
        in_valid = 1'b1; u_in = 14'd42; iss_prod = 14'd17; in_inv = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (stage_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_stage_done: got %b expected 0", stage_done); end
        checks++; if (bf_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_bf_cnt: got %0d expected 0", bf_cnt); end
        checks++; if (x_out !== 14'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d expected 0", x_out); end
        checks++; if (y_out !== 14'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d expected 0", y_out); end
        rst = 1'b1; in_valid = 1'b0; u_in = '0; iss_prod = IDLE_PROD;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL reset_ignored_issue: got %0d outputs expected 0", stray); end
    endtask

    task automatic test_basic();
        logic [13:0] xo, yo;
        int lat;
        run_single(14'd5, 14'd7, 1'b0, xo, yo, lat);
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 6", lat); end
        checks++; if (xo !== 14'd12) begin errors++; $display("[TB] FAIL basic_x: got %0d expected 12", xo); end
        checks++; if (yo !== 14'd12287) begin errors++; $display("[TB] FAIL basic_y: got %0d expected 12287", yo); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_single_pulse: got %b expected 0", out_valid); end
        checks++; if (x_out !== 14'd12) begin errors++; $display("[TB] FAIL basic_x_hold: got %0d expected 12", x_out); end
        checks++; if (bf_cnt !== 8'd1) begin errors++; $display("[TB] FAIL basic_bf_cnt: got %0d expected 1", bf_cnt); end
    endtask

    task automatic test_wrap();
        logic [13:0] xo, yo;
        int lat;
        run_single(14'd12288, 14'd1, 1'b0, xo, yo, lat);
        checks++; if (xo !== 14'd0) begin errors++; $display("[TB] FAIL wrap_hi_x: got %0d expected 0", xo); end
        checks++; if (yo !== 14'd12287) begin errors++; $display("[TB] FAIL wrap_hi_y: got %0d expected 12287", yo); end
        run_single(14'd0, 14'd0, 1'b0, xo, yo, lat);
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL wrap_zero_latency: got %0d expected 6", lat); end
        checks++; if (xo !== 14'd0) begin errors++; $display("[TB] FAIL wrap_zero_x: got %0d expected 0", xo); end
        checks++; if (yo !== 14'd0) begin errors++; $display("[TB] FAIL wrap_zero_y: got %0d expected 0", yo); end
        run_single(14'd100, 14'd12000, 1'b0, xo, yo, lat);
        checks++; if (xo !== 14'd12100) begin errors++; $display("[TB] FAIL wrap_mid_x: got %0d expected 12100", xo); end
        checks++; if (yo !== 14'd389) begin errors++; $display("[TB] FAIL wrap_mid_y: got %0d expected 389", yo); end
    endtask

    task automatic test_halving();
        logic [13:0] xo, yo, ex1, ey1, ex2, ey2;
        int lat;
`ifdef NTT_BFU_HALVE_EN
        ex1 = 14'd6146; ey1 = 14'd6146; ex2 = 14'd3; ey2 = 14'd1;
`else
        ex1 = 14'd3; ey1 = 14'd3; ex2 = 14'd6; ey2 = 14'd2;
`endif
        run_single(14'd3, 14'd0, 1'b1, xo, yo, lat);
        checks++; if (xo !== ex1) begin errors++; $display("[TB] FAIL halve_odd_x: got %0d expected %0d", xo, ex1); end
        checks++; if (yo !== ey1) begin errors++; $display("[TB] FAIL halve_odd_y: got %0d expected %0d", yo, ey1); end
        run_single(14'd4, 14'd2, 1'b1, xo, yo, lat);
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL halve_latency: got %0d expected 6", lat); end
        checks++; if (xo !== ex2) begin errors++; $display("[TB] FAIL halve_even_x: got %0d expected %0d", xo, ex2); end
        checks++; if (yo !== ey2) begin errors++; $display("[TB] FAIL halve_even_y: got %0d expected %0d", yo, ey2); end
        run_single(14'd5, 14'd3, 1'b0, xo, yo, lat);
        checks++; if (xo !== 14'd8) begin errors++; $display("[TB] FAIL forward_x: got %0d expected 8", xo); end
        checks++; if (yo !== 14'd2) begin errors++; $display("[TB] FAIL forward_y: got %0d expected 2", yo); end
    endtask

    task automatic test_stage_count();
        int n_valid, first_t, last_t, n_done, done_t, j;
        logic [13:0] uj, pj, ex, ey;
        do_reset();
        n_valid = 0; first_t = -1; last_t = -1; n_done = 0; done_t = -1;
        for (int t = 0; t < 266; t++) begin
            if (t < 256) begin
                in_valid = 1'b1;
                u_in     = 14'((t * 97 + 11) % QV);
                iss_prod = 14'((t * 211 + 5) % QV);
            end else begin
                in_valid = 1'b0; u_in = '0; iss_prod = IDLE_PROD;
            end
            @(negedge clk);
            if (out_valid === 1'b1) begin
                n_valid++;
                if (first_t < 0) first_t = t;
                last_t = t;
                j  = t - 5;
                uj = 14'((j * 97 + 11) % QV);
                pj = 14'((j * 211 + 5) % QV);
                ex = 14'((int'(uj) + int'(pj)) % QV);
                ey = 14'((int'(uj) - int'(pj) + QV) % QV);
                checks++;
                if (x_out !== ex || y_out !== ey) begin
                    errors++;
                    $display("[TB] FAIL stage_data j=%0d: got x=%0d y=%0d expected x=%0d y=%0d", j, x_out, y_out, ex, ey);
                end
            end
            if (stage_done === 1'b1) begin
                n_done++;
                done_t = t;
            end
            if (t == 133) begin
                checks++; if (bf_cnt !== 8'd128) begin errors++; $display("[TB] FAIL stage_bf_cnt_mid: got %0d expected 128", bf_cnt); end
            end
            if (t == 260) begin
                checks++; if (bf_cnt !== 8'd255) begin errors++; $display("[TB] FAIL stage_bf_cnt_last: got %0d expected 255", bf_cnt); end
            end
        end
        checks++; if (n_valid !== 256) begin errors++; $display("[TB] FAIL stage_valid_count: got %0d expected 256", n_valid); end
        checks++; if (first_t !== 5) begin errors++; $display("[TB] FAIL stage_first_valid: got %0d expected 5", first_t); end
        checks++; if (last_t !== 260) begin errors++; $display("[TB] FAIL stage_last_valid: got %0d expected 260", last_t); end
        checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL stage_done_count: got %0d expected 1", n_done); end
        checks++; if (done_t !== 260) begin errors++; $display("[TB] FAIL stage_done_pos: got %0d expected 260", done_t); end
        checks++; if (bf_cnt !== 8'd0) begin errors++; $display("[TB] FAIL stage_bf_cnt_wrap: got %0d expected 0", bf_cnt); end
    endtask

    task automatic test_bubbles();
        logic        pat [6];
        logic [13:0] us [6];
        logic [13:0] ps [6];
        logic        ev;
        int          j;
        logic [13:0] ex, ey;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        us  = '{14'd10,  14'd0, 14'd20,   14'd12280, 14'd0, 14'd7};
        ps  = '{14'd300, 14'd0, 14'd12289 - 14'd5, 14'd15, 14'd0, 14'd7};
        for (int t = 0; t < 14; t++) begin
            if (t < 6) begin
                in_valid = pat[t];
                u_in     = pat[t] ? us[t] : 14'd555;
                iss_prod = pat[t] ? ps[t] : IDLE_PROD;
            end else begin
                in_valid = 1'b0; u_in = '0; iss_prod = IDLE_PROD;
            end
            @(negedge clk);
            j  = t - 5;
            ev = (j >= 0 && j < 6) ? pat[j] : 1'b0;
            checks++;
            if (out_valid !== ev) begin
                errors++;
                $display("[TB] FAIL bubble_valid t=%0d: got %b expected %b", t, out_valid, ev);
            end
            if (ev) begin
                ex = 14'((int'(us[j]) + int'(ps[j])) % QV);
                ey = 14'((int'(us[j]) - int'(ps[j]) + QV) % QV);
                checks++;
                if (x_out !== ex || y_out !== ey) begin
                    errors++;
                    $display("[TB] FAIL bubble_data j=%0d: got x=%0d y=%0d expected x=%0d y=%0d", j, x_out, y_out, ex, ey);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [13:0] xo, yo;
        int lat, stray;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; u_in = 14'(100 + i); iss_prod = 14'(200 + i);
            @(negedge clk);
        end
        rst = 1'b0; in_valid = 1'b1; u_in = 14'd777; iss_prod = 14'd888;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (bf_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset_bf_cnt: got %0d expected 0", bf_cnt); end
        checks++; if (x_out !== 14'd0) begin errors++; $display("[TB] FAIL mid_reset_x: got %0d expected 0", x_out); end
        rst = 1'b1; in_valid = 1'b0; u_in = '0; iss_prod = IDLE_PROD;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) stray++;
        end
        checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL mid_reset_flushed: got %0d outputs expected 0", stray); end
        run_single(14'd50, 14'd60, 1'b0, xo, yo, lat);
        checks++; if (lat !== 6) begin errors++; $display("[TB] FAIL mid_reset_new_latency: got %0d expected 6", lat); end
        checks++; if (xo !== 14'd110) begin errors++; $display("[TB] FAIL mid_reset_new_x: got %0d expected 110", xo); end
        checks++; if (yo !== 14'd12279) begin errors++; $display("[TB] FAIL mid_reset_new_y: got %0d expected 12279", yo); end
        @(negedge clk);
        checks++; if (bf_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_reset_new_bf_cnt: got %0d expected 1", bf_cnt); end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inv = 1'b0; u_in = '0; iss_prod = IDLE_PROD;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_halving();
        test_stage_count();
        test_bubbles();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
